// File: rtl/mandelbrot_engine_scheduler.sv
// Round-robin pixel dispatch to N depth engines with in-order (raster) colour retirement; optional perf counters under SCHED_PERF_COUNTERS_EN.
// Latency: first eng_start two cycles after run is sampled in IDLE; pix_valid follows the retiring engine's eng_done by one edge.
// Backpressure: pix_valid holds with stable data until pix_ready; HELD engines are never reissued, so issue stalls in order.
module mandelbrot_engine_scheduler #(
    parameter int N_ENGINES = 4,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int COORD_W   = 11
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      run,
    output logic [N_ENGINES-1:0]      eng_start,
    output logic [COORD_W-1:0]        eng_x,
    output logic [COORD_W-1:0]        eng_y,
    input  logic [N_ENGINES-1:0]      eng_done,
    input  logic [24*N_ENGINES-1:0]   eng_color,
    output logic [7:0]                pix_r,
    output logic [7:0]                pix_g,
    output logic [7:0]                pix_b,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      pix_sof,
    output logic                      pix_eol,
    output logic                      busy,
    output logic [31:0]               stall_cycles,
    output logic [15:0]               frame_count
);
    localparam int PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] E_FREE = 2'd0;
    localparam logic [1:0] E_BUSY = 2'd1;
    localparam logic [1:0] E_HELD = 2'd2;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(X_SIZE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(Y_SIZE - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(N_ENGINES - 1);

    logic [1:0]         state;
    logic [1:0]         eng_st [N_ENGINES];
    logic [23:0]        hold   [N_ENGINES];
    logic [COORD_W-1:0] issue_x;
    logic [COORD_W-1:0] issue_y;
    logic [COORD_W-1:0] retire_x;
    logic [COORD_W-1:0] retire_y;
    logic [PTR_W-1:0]   issue_ptr;
    logic [PTR_W-1:0]   retire_ptr;
    logic               issue_fire;
    logic               last_issue;
    logic               retire_fire;
    logic               all_free;

    always_comb begin
        all_free = 1'b1;
        for (int i = 0; i < N_ENGINES; i++) begin
            if (eng_st[i] != E_FREE) begin
                all_free = 1'b0;
            end
        end
    end

    // Issue never skips a non-FREE engine, so engine k only ever sees pixels with index mod N == k.
    assign issue_fire  = (state == S_RUN) && (eng_st[issue_ptr] == E_FREE);
    assign last_issue  = issue_fire && (issue_x == X_LAST) && (issue_y == Y_LAST);
    assign pix_valid   = (eng_st[retire_ptr] == E_HELD);
    assign retire_fire = pix_valid && pix_ready;
    assign {pix_r, pix_g, pix_b} = hold[retire_ptr];
    assign pix_sof     = (retire_x == '0) && (retire_y == '0);
    assign pix_eol     = (retire_x == X_LAST);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= S_IDLE;
            eng_start  <= '0;
            eng_x      <= '0;
            eng_y      <= '0;
            issue_x    <= '0;
            issue_y    <= '0;
            retire_x   <= '0;
            retire_y   <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            for (int i = 0; i < N_ENGINES; i++) begin
                eng_st[i] <= E_FREE;
                hold[i]   <= '0;
            end
        end else begin
            eng_start <= '0;

            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Frame size need not be a multiple of N, so pointers are realigned here.
                    if (all_free) begin
                        state      <= run ? S_RUN : S_IDLE;
                        issue_x    <= '0;
                        issue_y    <= '0;
                        retire_x   <= '0;
                        retire_y   <= '0;
                        issue_ptr  <= '0;
                        retire_ptr <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue_fire) begin
                eng_start <= N_ENGINES'(1) << issue_ptr;
                eng_x     <= issue_x;
                eng_y     <= issue_y;
                if (issue_x == X_LAST) begin
                    issue_x <= '0;
                    issue_y <= (issue_y == Y_LAST) ? '0 : issue_y + COORD_W'(1);
                end else begin
                    issue_x <= issue_x + COORD_W'(1);
                end
                issue_ptr <= (issue_ptr == PTR_LAST) ? '0 : issue_ptr + PTR_W'(1);
            end

            if (retire_fire) begin
                if (retire_x == X_LAST) begin
                    retire_x <= '0;
                    retire_y <= (retire_y == Y_LAST) ? '0 : retire_y + COORD_W'(1);
                end else begin
                    retire_x <= retire_x + COORD_W'(1);
                end
                retire_ptr <= (retire_ptr == PTR_LAST) ? '0 : retire_ptr + PTR_W'(1);
            end

            // Issue, capture and retire act on disjoint engine states, so at most one fires per engine.
            for (int i = 0; i < N_ENGINES; i++) begin
                if (issue_fire && (issue_ptr == PTR_W'(i))) begin
                    eng_st[i] <= E_BUSY;
                end else if ((eng_st[i] == E_BUSY) && eng_done[i] && !eng_start[i]) begin
                    eng_st[i] <= E_HELD;
                    hold[i]   <= eng_color[24*i +: 24];
                end else if (retire_fire && (retire_ptr == PTR_W'(i))) begin
                    eng_st[i] <= E_FREE;
                end
            end
        end
    end

`ifdef SCHED_PERF_COUNTERS_EN
    logic [31:0] stall_q;
    logic [15:0] frame_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            stall_q <= '0;
            frame_q <= '0;
        end else begin
            if (pix_valid && !pix_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if ((state == S_DRAIN) && all_free) begin
                frame_q <= frame_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign frame_count  = frame_q;
`else
    assign stall_cycles = '0;
    assign frame_count  = '0;
`endif

endmodule

// File: tb/tb_mandelbrot_engine_scheduler.sv
// Randomised bench for mandelbrot_engine_scheduler: behavioural engines plus a raster-order scoreboard.
module tb_mandelbrot_engine_scheduler;
    localparam int N    = 4;
    localparam int XS   = 8;
    localparam int YS   = 2;
    localparam int NPIX = XS * YS;
    localparam int CW   = 11;

`ifdef SCHED_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic            run       = 1'b0;
    logic            pix_ready = 1'b1;
    logic [N-1:0]    eng_start;
    logic [CW-1:0]   eng_x, eng_y;
    logic [N-1:0]    eng_done  = '0;
    logic [24*N-1:0] eng_color = '0;
    logic [7:0]      pix_r, pix_g, pix_b;
    logic            pix_valid, pix_sof, pix_eol, busy;
    logic [31:0]     stall_cycles;
    logic [15:0]     frame_count;

    // Single-engine instance for the serial-sequencer case.
    logic            s_run   = 1'b0;
    logic            s_ready = 1'b1;
    logic [0:0]      s_start;
    logic [0:0]      s_done  = '0;
    logic [23:0]     s_color = '0;
    logic [CW-1:0]   s_x, s_y;
    logic [7:0]      s_r, s_g, s_b;
    logic            s_valid, s_sof, s_eol, s_busy;
    logic [31:0]     s_stall;
    logic [15:0]     s_frames;

    int checks     = 0;
    int passed     = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    mandelbrot_engine_scheduler #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .COORD_W(CW)) dut (
        .sysclk(clk), .reset(reset), .run(run),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_color(eng_color),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy),
        .stall_cycles(stall_cycles), .frame_count(frame_count)
    );

    mandelbrot_engine_scheduler #(.N_ENGINES(1), .X_SIZE(XS), .Y_SIZE(YS), .COORD_W(CW)) dut_serial (
        .sysclk(clk), .reset(reset), .run(s_run),
        .eng_start(s_start), .eng_x(s_x), .eng_y(s_y),
        .eng_done(s_done), .eng_color(s_color),
        .pix_r(s_r), .pix_g(s_g), .pix_b(s_b),
        .pix_valid(s_valid), .pix_ready(s_ready),
        .pix_sof(s_sof), .pix_eol(s_eol), .busy(s_busy),
        .stall_cycles(s_stall), .frame_count(s_frames)
    );

    // Behavioural engines: random latency, colour = {y, x, engine id}; they share the reset.
    int          lat_min = 5;
    int          lat_max = 5;
    logic [N-1:0] inject = '0;
    int          cnt [N] = '{default: 0};
    logic [7:0]  ex [N];
    logic [7:0]  ey [N];
    int          s_cnt = 0;
    logic [7:0]  s_ex, s_ey;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            eng_done[i] = inject[i];
            if (reset) begin
                cnt[i] = 0;
            end else if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0) begin
                    eng_done[i] = 1'b1;
                    eng_color[24*i +: 24] = {ey[i], ex[i], 8'(i)};
                end
            end
            if (eng_start[i] === 1'b1 && !reset) begin
                cnt[i] = $urandom_range(lat_max, lat_min);
                ex[i]  = eng_x[7:0];
                ey[i]  = eng_y[7:0];
            end
        end
        s_done = 1'b0;
        if (reset) begin
            s_cnt = 0;
        end else if (s_cnt > 0) begin
            s_cnt = s_cnt - 1;
            if (s_cnt == 0) begin
                s_done  = 1'b1;
                s_color = {s_ey, s_ex, 8'h00};
            end
        end
        if (s_start[0] === 1'b1 && !reset) begin
            s_cnt = 3;
            s_ex  = s_x[7:0];
            s_ey  = s_y[7:0];
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (eng_start !== '0) $display("FAIL rst_eng_start got %b want 0", eng_start); else passed++;
        checks++; if (eng_x !== '0 || eng_y !== '0) $display("FAIL rst_eng_xy got %0d,%0d want 0,0", eng_x, eng_y); else passed++;
        checks++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid got %b want 0", pix_valid); else passed++;
        checks++; if (pix_sof !== 1'b1) $display("FAIL rst_pix_sof got %b want 1", pix_sof); else passed++;
        checks++; if (pix_eol !== 1'b0) $display("FAIL rst_pix_eol got %b want 0", pix_eol); else passed++;
        checks++; if ({pix_r, pix_g, pix_b} !== 24'h0) $display("FAIL rst_pix_rgb got %h want 0", {pix_r, pix_g, pix_b}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        checks++; if (stall_cycles !== 32'd0) $display("FAIL rst_stall got %0d want 0", stall_cycles); else passed++;
        checks++; if (frame_count !== 16'd0) $display("FAIL rst_frames got %0d want 0", frame_count); else passed++;
        reset      = 1'b0;
        exp_frames = 0;
    endtask

    // Runs nframes frames from IDLE and scoreboards every issue and every retirement.
    task automatic run_frame(input int lmin, input int lmax, input int rpct, input int nframes, input bit drop_mid);
        int          total, issued, retired, cyc, first, p;
        bit          inflight [N];
        bit          stalled;
        logic [23:0] held_rgb;
        total = nframes * NPIX; issued = 0; retired = 0; cyc = 0; first = -1;
        stalled = 1'b0; held_rgb = '0;
        for (int i = 0; i < N; i++) inflight[i] = 1'b0;
        lat_min = lmin; lat_max = lmax;
        @(negedge clk);
        run = 1'b1;
        while (retired < total && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            pix_ready = ($urandom_range(99) < rpct);
            if (eng_start !== '0) begin
                p = issued % NPIX;
                if (first < 0) first = cyc;
                checks++;
                if (issued >= total || eng_start !== (N'(1) << (p % N)) || eng_x !== CW'(p % XS)
                    || eng_y !== CW'(p / XS) || inflight[p % N])
                    $display("FAIL issue_%0d got start=%b x=%0d y=%0d want start=%b x=%0d y=%0d on a free engine (engine_busy=%0b)",
                             issued, eng_start, eng_x, eng_y, N'(1) << (p % N), p % XS, p / XS, inflight[p % N]);
                else passed++;
                inflight[p % N] = 1'b1;
                issued++;
                if (issued == total || (drop_mid && issued == 3)) run = 1'b0;
            end
            if (stalled) begin
                checks++;
                if (pix_valid !== 1'b1 || {pix_r, pix_g, pix_b} !== held_rgb)
                    $display("FAIL stall_hold got valid=%b rgb=%h want valid=1 rgb=%h", pix_valid, {pix_r, pix_g, pix_b}, held_rgb);
                else passed++;
            end
            if (pix_valid === 1'b1 && pix_ready) begin
                p = retired % NPIX;
                checks++;
                if ({pix_r, pix_g, pix_b} !== {8'(p / XS), 8'(p % XS), 8'(p % N)} || pix_sof !== (p == 0)
                    || pix_eol !== (p % XS == XS - 1))
                    $display("FAIL retire_%0d got rgb=%h sof=%b eol=%b want rgb=%h sof=%b eol=%b", retired,
                             {pix_r, pix_g, pix_b}, pix_sof, pix_eol, {8'(p / XS), 8'(p % XS), 8'(p % N)},
                             p == 0, p % XS == XS - 1);
                else passed++;
                inflight[p % N] = 1'b0;
                retired++;
            end
            stalled  = (pix_valid === 1'b1) && !pix_ready;
            held_rgb = {pix_r, pix_g, pix_b};
        end
        checks++; if (retired != total) $display("FAIL frame_timeout got %0d pixels want %0d", retired, total); else passed++;
        checks++; if (first != 2) $display("FAIL first_issue_latency got %0d cycles want 2", first); else passed++;
        cyc = 0;
        p   = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (eng_start !== '0) p++;
        end
        exp_frames += nframes;
        checks++; if (busy !== 1'b0 || p != 0) $display("FAIL drain_idle got busy=%b extra_starts=%0d want busy=0 extra_starts=0", busy, p); else passed++;
        checks++; if (frame_count !== (PERF ? 16'(exp_frames) : 16'd0))
            $display("FAIL frame_count got %0d want %0d", frame_count, PERF ? exp_frames : 0); else passed++;
    endtask

    task automatic test_raster_fixed;
        run_frame(5, 5, 100, 1, 1'b0);
    endtask

    task automatic test_run_drop;
        run_frame(1, 12, 80, 1, 1'b1);
    endtask

    task automatic test_random_latency;
        run_frame(1, 40, 70, 2, 1'b0);
    endtask

    task automatic test_backpressure;
        int          starts, obs, unstable;
        logic [23:0] rgb0;
        run = 1'b0; pix_ready = 1'b0; lat_min = 2; lat_max = 2;
        test_reset();
        @(negedge clk);
        run = 1'b1;
        starts = 0; obs = 0; unstable = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (eng_start !== '0) starts++;
            if (pix_valid === 1'b1) obs++;
        end
        rgb0 = {pix_r, pix_g, pix_b};
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (eng_start !== '0) starts++;
            if (pix_valid === 1'b1) obs++;
            if (pix_valid !== 1'b1 || {pix_r, pix_g, pix_b} !== rgb0) unstable++;
        end
        @(negedge clk);
        checks++; if (starts != N) $display("FAIL bp_starts got %0d want %0d", starts, N); else passed++;
        checks++; if (unstable != 0) $display("FAIL bp_stable got %0d changed cycles want 0", unstable); else passed++;
        checks++; if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || {pix_r, pix_g, pix_b} !== 24'h000000)
            $display("FAIL bp_head got valid=%b sof=%b rgb=%h want 1 1 000000", pix_valid, pix_sof, {pix_r, pix_g, pix_b}); else passed++;
        checks++; if (stall_cycles !== (PERF ? 32'(obs) : 32'd0))
            $display("FAIL bp_stall_cycles got %0d want %0d", stall_cycles, PERF ? obs : 0); else passed++;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset_midframe;
        int starts, cyc, vld;
        run = 1'b0; pix_ready = 1'b1; lat_min = 30; lat_max = 30;
        test_reset();
        @(negedge clk);
        run = 1'b1;
        starts = 0; cyc = 0;
        while (starts < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (eng_start !== '0) starts++;
        end
        checks++; if (starts != 3) $display("FAIL midreset_setup got %0d starts want 3", starts); else passed++;
        run = 1'b0;
        test_reset();
        inject = '1;
        @(negedge clk);
        @(negedge clk);
        inject = '0;
        vld = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pix_valid !== 1'b0 || busy !== 1'b0 || eng_start !== '0) vld++;
        end
        checks++; if (vld != 0) $display("FAIL spurious_done got %0d active cycles want 0", vld); else passed++;
    endtask

    task automatic test_serial;
        int issued, retired, cyc;
        issued = 0; retired = 0; cyc = 0;
        @(negedge clk);
        s_run = 1'b1;
        while (retired < NPIX && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (s_start[0] === 1'b1) begin
                checks++;
                if (issued >= NPIX || issued != retired || s_x !== CW'(issued % XS) || s_y !== CW'(issued / XS))
                    $display("FAIL serial_issue_%0d got x=%0d y=%0d retired=%0d want x=%0d y=%0d retired=%0d",
                             issued, s_x, s_y, retired, issued % XS, issued / XS, issued);
                else passed++;
                issued++;
                if (issued == NPIX) s_run = 1'b0;
            end
            if (s_valid === 1'b1 && s_ready) begin
                checks++;
                if ({s_r, s_g, s_b} !== {8'(retired / XS), 8'(retired % XS), 8'h00} || s_sof !== (retired == 0)
                    || s_eol !== (retired % XS == XS - 1))
                    $display("FAIL serial_retire_%0d got rgb=%h sof=%b eol=%b want rgb=%h", retired,
                             {s_r, s_g, s_b}, s_sof, s_eol, {8'(retired / XS), 8'(retired % XS), 8'h00});
                else passed++;
                retired++;
            end
        end
        cyc = 0;
        while (s_busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (retired != NPIX || s_busy !== 1'b0)
            $display("FAIL serial_frame got %0d pixels busy=%b want %0d busy=0", retired, s_busy, NPIX); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raster_fixed();
        test_run_drop();
        test_random_latency();
        test_backpressure();
        test_reset_midframe();
        test_serial();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
